// File: rtl/game_2048_pkg.sv
// rtl/game_2048_pkg.sv - shared types and direction priority for the move input controller
package game_2048_pkg;

    localparam int NUM_BUTTONS = 4;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } direction_t;

    typedef enum logic [1:0] {
        ST_WAIT_REL = 2'b00,
        ST_IDLE     = 2'b01,
        ST_PENDING  = 2'b10
    } ctrl_state_t;

    // Lowest button index wins: up > down > left > right.
    function automatic direction_t pick_direction(input logic [NUM_BUTTONS-1:0] lvl);
        direction_t d;
        d = DIR_RIGHT;
        if (lvl[0]) begin
            d = DIR_UP;
        end else if (lvl[1]) begin
            d = DIR_DOWN;
        end else if (lvl[2]) begin
            d = DIR_LEFT;
        end
        return d;
    endfunction

endpackage

// File: rtl/move_input_ctrl_if.sv
// rtl/move_input_ctrl_if.sv - pushbutton inputs and move handshake bundle
interface move_input_ctrl_if;
    logic [3:0] btn_raw;
    logic       accept;
    logic       move_valid;
    logic [1:0] direction;
    logic [3:0] pressed;

    modport master (
        output btn_raw,
        output accept,
        input  move_valid,
        input  direction,
        input  pressed
    );

    modport slave (
        input  btn_raw,
        input  accept,
        output move_valid,
        output direction,
        output pressed
    );
endinterface

// File: rtl/move_input_ctrl_debouncer.sv
// rtl/move_input_ctrl_debouncer.sv - one button: inverting synchronizer plus stable-level counter
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic released
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], ~btn_n};
            // Any disagreement that does not persist restarts the stability count.
            if (sync[SYNC_STAGES-1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Nothing pressed and nothing in flight through the synchronizer.
    assign released = (sync == '0) && !level;

endmodule

// File: rtl/move_input_ctrl.sv
// rtl/move_input_ctrl.sv - debounced pushbuttons to single move handshake; AUTO_REPEAT_EN adds held-button repeat
module move_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    move_input_ctrl_if.slave  bus
);
    import game_2048_pkg::*;

    logic [NUM_BUTTONS-1:0] level;
    logic [NUM_BUTTONS-1:0] released;
    ctrl_state_t            state, state_nx;
    direction_t             dir_q, dir_nx;
    logic                   armed;
    logic                   rpt_hit;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_deb (
            .clk      (clk),
            .rst      (rst),
            .btn_n    (bus.btn_raw[i]),
            .level    (level[i]),
            .released (released[i])
        );
    end

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    logic [RW-1:0] rpt_cnt;

    assign rpt_hit = (state == ST_WAIT_REL) && level[dir_q] && (rpt_cnt == RW'(REPEAT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst || state != ST_WAIT_REL || !level[dir_q] || rpt_hit) begin
            rpt_cnt <= '0;
        end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end
`else
    assign rpt_hit = 1'b0;
`endif

    // The synchronizers read as released for one edge after reset; armed masks
    // that edge so a button held through reset is not mistaken for a release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_WAIT_REL;
            dir_q <= DIR_UP;
            armed <= 1'b0;
        end else begin
            state <= state_nx;
            dir_q <= dir_nx;
            armed <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        dir_nx   = dir_q;
        case (state)
            ST_WAIT_REL: begin
                if (rpt_hit) begin
                    state_nx = ST_PENDING;
                end else if (armed && (&released)) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (level != '0) begin
                    state_nx = ST_PENDING;
                    dir_nx   = pick_direction(level);
                end
            end
            ST_PENDING: begin
                if (bus.accept) begin
                    state_nx = ST_WAIT_REL;
                end
            end
            default: state_nx = ST_WAIT_REL;
        endcase
    end

    assign bus.move_valid = (state == ST_PENDING);
    assign bus.direction  = dir_q;
    assign bus.pressed    = level;

endmodule

// File: tb/tb_move_input_ctrl.sv
// tb/tb_move_input_ctrl.sv - directed bench for move_input_ctrl (D=4, S=2, R=8)
module tb_move_input_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    move_input_ctrl_if bus();

    move_input_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2),
        .REPEAT_CYCLES   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_accept();
        bus.accept = 1'b1;
        tick(1);
        bus.accept = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b0;
        bus.btn_raw = 4'hF;
        bus.accept  = 1'b0;
        tick(3);
        check("rst_valid", bus.move_valid, 0);
        check("rst_dir", bus.direction, 0);
        check("rst_pressed", bus.pressed, 0);
        rst = 1'b1;
        tick(3);

        // Left held from edge 0: move exactly at edge 7.
        bus.btn_raw = 4'b1011;
        tick(7);
        check("lat_edge6", bus.move_valid, 0);
        tick(1);
        check("lat_edge7", bus.move_valid, 1);
        check("left_dir", bus.direction, 2);
        check("left_pressed", bus.pressed, 4'b0100);
        tick(5);
        check("left_hold", bus.move_valid, 1);
        pulse_accept();
        check("left_accept", bus.move_valid, 0);
        bus.btn_raw = 4'hF;
        tick(12);
        check("left_rel_pressed", bus.pressed, 0);

        // Down bouncing every 2 cycles never settles.
        for (int i = 0; i < 10; i++) begin
            bus.btn_raw = (i % 2 == 0) ? 4'b1101 : 4'hF;
            tick(2);
            check("bounce_pressed", bus.pressed, 0);
            check("bounce_valid", bus.move_valid, 0);
        end
        bus.btn_raw = 4'hF;
        tick(10);
        check("bounce_end", bus.move_valid, 0);

        // Right and up together: up wins, no second move while held.
        bus.btn_raw = 4'b0110;
        tick(8);
        check("dual_valid", bus.move_valid, 1);
        check("dual_dir", bus.direction, 0);
        check("dual_pressed", bus.pressed, 4'b1001);
        pulse_accept();
        check("dual_accept", bus.move_valid, 0);
`ifndef AUTO_REPEAT_EN
        tick(20);
        check("dual_no_second", bus.move_valid, 0);
`endif
        bus.btn_raw = 4'hF;
        tick(12);

        // Reset during a pending move with the button held.
        bus.btn_raw = 4'b1101;
        tick(8);
        check("rstmid_valid", bus.move_valid, 1);
        check("rstmid_dir", bus.direction, 1);
        rst = 1'b0;
        tick(1);
        check("rstmid_drop", bus.move_valid, 0);
        check("rstmid_pressed", bus.pressed, 0);
        rst = 1'b1;
        tick(20);
        check("rstmid_held", bus.move_valid, 0);
        check("rstmid_held_pressed", bus.pressed, 4'b0010);
        bus.btn_raw = 4'hF;
        tick(12);
        check("rstmid_released", bus.move_valid, 0);
        bus.btn_raw = 4'b1101;
        tick(8);
        check("rstmid_repress", bus.move_valid, 1);
        check("rstmid_repress_dir", bus.direction, 1);
        pulse_accept();
        bus.btn_raw = 4'hF;
        tick(12);

        // Accept in IDLE is ignored; direction frozen during PENDING.
        bus.accept = 1'b1;
        tick(2);
        bus.accept  = 1'b0;
        bus.btn_raw = 4'b1110;
        tick(8);
        check("idleacc_valid", bus.move_valid, 1);
        check("idleacc_dir", bus.direction, 0);
        bus.btn_raw = 4'b0111;
        tick(10);
        check("pend_change_valid", bus.move_valid, 1);
        check("pend_change_dir", bus.direction, 0);
        pulse_accept();
        check("idleacc_accept", bus.move_valid, 0);
        bus.btn_raw = 4'hF;
        tick(12);

`ifdef AUTO_REPEAT_EN
        bus.btn_raw = 4'b1101;
        tick(8);
        check("rpt_first", bus.move_valid, 1);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            pulse_accept();
            check("rpt_cleared", bus.move_valid, 0);
            tick(7);
            check("rpt_early", bus.move_valid, 0);
            tick(1);
            check("rpt_again", bus.move_valid, 1);
            check("rpt_dir", bus.direction, 1);
        end
        tick(1);
        pulse_accept();
        bus.btn_raw = 4'hF;
        tick(20);
        check("rpt_stop", bus.move_valid, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
